// File: rtl/mux_n_pipe.sv
// N-input operand multiplexer followed by a LATENCY-deep register pipeline with stall, flush and valid tracking.
// Optional build macro MUX_N_PIPE_SELERR_EN adds a per-item out-of-range tag and a saturating error counter.
module mux_n_pipe #(
    parameter int NUM_IN  = 3,
    parameter int DATA_W  = 16,
    parameter int LATENCY = 1,
    parameter int SEL_W   = $clog2(NUM_IN)
) (
    input  logic                     clk,
    input  logic                     arst_n,
    input  logic                     en,
    input  logic                     flush,
    input  logic                     in_valid,
    input  logic [NUM_IN*DATA_W-1:0] in_data,
    input  logic [SEL_W-1:0]         sel,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_valid,
    output logic                     sel_err,
    output logic [7:0]               err_cnt
);

    logic [DATA_W-1:0] chan [NUM_IN];
    logic [DATA_W-1:0] sel_data;
    logic [DATA_W-1:0] stage_in_data;

    generate
        for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_chan
            assign chan[gi] = in_data[gi*DATA_W +: DATA_W];
        end
    endgenerate

    // Out-of-range selects fall through to channel 0 because no other channel matches.
    always_comb begin
        sel_data = chan[0];
        for (int k = 1; k < NUM_IN; k++) begin
            if (sel == SEL_W'(k)) begin
                sel_data = chan[k];
            end
        end
    end

    assign stage_in_data = in_valid ? sel_data : '0;

    logic [DATA_W-1:0]  data_q  [LATENCY];
    logic [DATA_W-1:0]  data_d  [LATENCY];
    logic [LATENCY-1:0] valid_q;
    logic [LATENCY-1:0] valid_d;

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        if (flush) begin
            for (int i = 0; i < LATENCY; i++) begin
                data_d[i] = '0;
            end
            valid_d = '0;
        end else if (en) begin
            data_d[0]  = stage_in_data;
            valid_d[0] = in_valid;
            for (int i = 1; i < LATENCY; i++) begin
                data_d[i]  = data_q[i-1];
                valid_d[i] = valid_q[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            for (int i = 0; i < LATENCY; i++) begin
                data_q[i] <= '0;
            end
            valid_q <= '0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign out_data  = data_q[LATENCY-1];
    assign out_valid = valid_q[LATENCY-1];

`ifdef MUX_N_PIPE_SELERR_EN
    logic               sel_in_range;
    logic               stage_in_err;
    logic [LATENCY-1:0] err_q;
    logic [LATENCY-1:0] err_d;
    logic [7:0]         err_cnt_q;
    logic [7:0]         err_cnt_d;

    assign sel_in_range = ({1'b0, sel} < (SEL_W+1)'(NUM_IN));
    assign stage_in_err = in_valid && !sel_in_range;

    // The tag shifts in lock-step with data/valid so it stays aligned with its item.
    always_comb begin
        err_d     = err_q;
        err_cnt_d = err_cnt_q;
        if (flush) begin
            err_d = '0;
        end else if (en) begin
            err_d[0] = stage_in_err;
            for (int i = 1; i < LATENCY; i++) begin
                err_d[i] = err_q[i-1];
            end
            if (stage_in_err && (err_cnt_q != 8'hFF)) begin
                err_cnt_d = err_cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            err_q     <= '0;
            err_cnt_q <= '0;
        end else begin
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign sel_err = err_q[LATENCY-1];
    assign err_cnt = err_cnt_q;
`else
    assign sel_err = 1'b0;
    assign err_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_mux_n_pipe.sv
// Randomized + directed bench for mux_n_pipe: LATENCY=1 and LATENCY=3 instances share one stimulus stream.
module tb_mux_n_pipe;

    localparam int NUM_IN = 3;
    localparam int DATA_W = 16;
    localparam int SEL_W  = 2;
`ifdef MUX_N_PIPE_SELERR_EN
    localparam bit SELERR = 1'b1;
`else
    localparam bit SELERR = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                     arst_n;
    logic                     en;
    logic                     flush;
    logic                     in_valid;
    logic [SEL_W-1:0]         sel;
    logic [DATA_W-1:0]        ch [NUM_IN];
    logic [NUM_IN*DATA_W-1:0] in_data;

    logic [DATA_W-1:0] o1_data, o3_data;
    logic              o1_valid, o3_valid, o1_err, o3_err;
    logic [7:0]        o1_cnt, o3_cnt;

    assign in_data = {ch[2], ch[1], ch[0]};

    mux_n_pipe #(.NUM_IN(NUM_IN), .DATA_W(DATA_W), .LATENCY(1)) u_l1 (
        .clk(clk), .arst_n(arst_n), .en(en), .flush(flush), .in_valid(in_valid),
        .in_data(in_data), .sel(sel), .out_data(o1_data), .out_valid(o1_valid),
        .sel_err(o1_err), .err_cnt(o1_cnt)
    );

    mux_n_pipe #(.NUM_IN(NUM_IN), .DATA_W(DATA_W), .LATENCY(3)) u_l3 (
        .clk(clk), .arst_n(arst_n), .en(en), .flush(flush), .in_valid(in_valid),
        .in_data(in_data), .sel(sel), .out_data(o3_data), .out_valid(o3_valid),
        .sel_err(o3_err), .err_cnt(o3_cnt)
    );

    // Reference: each pipeline is a fixed-length FIFO of items; an advancing edge pushes one and pops the oldest.
    typedef struct packed {
        logic              v;
        logic [DATA_W-1:0] d;
        logic              e;
    } item_t;

    item_t q1[$];
    item_t q3[$];
    int    cnt_m;
    int    n_checks = 0;
    int    n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic item_t incoming();
        item_t it;
        it = '0;
        if (in_valid) begin
            it.v = 1'b1;
            if (int'(sel) < NUM_IN) it.d = ch[sel];
            else                    it.d = ch[0];
            it.e = (int'(sel) >= NUM_IN);
        end
        return it;
    endfunction

    task automatic model_reset();
        q1 = {};
        q3 = {};
        q1.push_back('0);
        for (int i = 0; i < 3; i++) q3.push_back('0);
        cnt_m = 0;
    endtask

    task automatic model_edge();
        item_t it;
        if (flush) begin
            for (int i = 0; i < 1; i++) q1[i] = '0;
            for (int i = 0; i < 3; i++) q3[i] = '0;
        end else if (en) begin
            it = incoming();
            q1.push_back(it);
            void'(q1.pop_front());
            q3.push_back(it);
            void'(q3.pop_front());
            if (it.e && cnt_m < 255) cnt_m++;
        end
    endtask

    task automatic compare();
        chk("l1_valid", {31'd0, o1_valid}, {31'd0, q1[0].v});
        chk("l1_data",  {16'd0, o1_data},  {16'd0, q1[0].d});
        chk("l1_selerr", {31'd0, o1_err}, {31'd0, SELERR & q1[0].e});
        chk("l1_errcnt", {24'd0, o1_cnt}, SELERR ? cnt_m : 0);
        chk("l3_valid", {31'd0, o3_valid}, {31'd0, q3[0].v});
        chk("l3_data",  {16'd0, o3_data},  {16'd0, q3[0].d});
        chk("l3_selerr", {31'd0, o3_err}, {31'd0, SELERR & q3[0].e});
        chk("l3_errcnt", {24'd0, o3_cnt}, SELERR ? cnt_m : 0);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare();
    endtask

    task automatic drive(input logic v, input logic [SEL_W-1:0] s, input logic e, input logic f);
        in_valid = v;
        sel      = s;
        en       = e;
        flush    = f;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_l1_valid"}, {31'd0, o1_valid}, 32'd0);
        chk({tag, "_l1_data"},  {16'd0, o1_data},  32'd0);
        chk({tag, "_l1_err"},   {31'd0, o1_err},   32'd0);
        chk({tag, "_l1_cnt"},   {24'd0, o1_cnt},   32'd0);
        chk({tag, "_l3_valid"}, {31'd0, o3_valid}, 32'd0);
        chk({tag, "_l3_data"},  {16'd0, o3_data},  32'd0);
        chk({tag, "_l3_err"},   {31'd0, o3_err},   32'd0);
        chk({tag, "_l3_cnt"},   {24'd0, o3_cnt},   32'd0);
    endtask

    initial begin
        arst_n = 1'b0;
        drive(1'b0, '0, 1'b0, 1'b0);
        ch[0] = 16'h1111;
        ch[1] = 16'h2222;
        ch[2] = 16'h3333;
        model_reset();
        #2;
        check_all_zero("reset");
        @(negedge clk);
        arst_n = 1'b1;

        // LATENCY=1: selected channel shows one edge later
        drive(1'b1, 2'd2, 1'b1, 1'b0);
        step();
        chk("l1_sel2", {16'd0, o1_data}, 32'h3333);
        drive(1'b1, 2'd0, 1'b1, 1'b0);
        step();
        chk("l1_sel0", {16'd0, o1_data}, 32'h1111);
        $display("directed: latency-1 select done");

        // LATENCY=3: back-to-back items 0,1,2
        drive(1'b0, 2'd0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, SEL_W'(i), 1'b1, 1'b0);
            step();
            if (i == 1) chk("l3_not_yet", {31'd0, o3_valid}, 32'd0);
        end
        drive(1'b0, 2'd0, 1'b1, 1'b0);
        chk("l3_item0", {16'd0, o3_data}, 32'h1111);
        step();
        chk("l3_item1", {16'd0, o3_data}, 32'h2222);
        step();
        chk("l3_item2", {16'd0, o3_data}, 32'h3333);
        step();
        chk("l3_after", {31'd0, o3_valid}, 32'd0);
        $display("directed: latency-3 stream done");

        // Stall two cycles with one item in flight; inputs during stall are dropped
        for (int i = 0; i < 2; i++) step();
        drive(1'b1, 2'd1, 1'b1, 1'b0);
        step();
        drive(1'b1, 2'd2, 1'b0, 1'b0);
        step();
        step();
        drive(1'b0, 2'd0, 1'b1, 1'b0);
        step();
        chk("stall_hold", {31'd0, o3_valid}, 32'd0);
        step();
        chk("stall_item", {16'd0, o3_data}, 32'h2222);
        step();
        chk("stall_drop", {31'd0, o3_valid}, 32'd0);
        $display("directed: stall done");

        // Flush with three items in flight
        for (int i = 0; i < 3; i++) begin
            ch[i] = 16'($urandom);
            drive(1'b1, SEL_W'($urandom_range(0, 2)), 1'b1, 1'b0);
            step();
        end
        drive(1'b1, 2'd1, 1'b1, 1'b1);
        step();
        chk("flush_valid", {31'd0, o3_valid}, 32'd0);
        chk("flush_data", {16'd0, o3_data}, 32'd0);
        drive(1'b1, 2'd1, 1'b1, 1'b0);
        step();
        drive(1'b0, 2'd0, 1'b1, 1'b0);
        step();
        step();
        chk("flush_resume", {16'd0, o3_data}, {16'd0, ch[1]});
        $display("directed: flush done");

        // Out-of-range select and counter saturation
        ch[0] = 16'h1111;
        drive(1'b1, 2'd3, 1'b1, 1'b0);
        step();
        chk("oor_data", {16'd0, o1_data}, 32'h1111);
        chk("oor_tag", {31'd0, o1_err}, {31'd0, SELERR});
        chk("oor_cnt1", {24'd0, o1_cnt}, SELERR ? 32'd1 : 32'd0);
        for (int i = 1; i < 300; i++) step();
        chk("oor_sat", {24'd0, o3_cnt}, SELERR ? 32'd255 : 32'd0);
        $display("directed: select error done");

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NUM_IN; i++) ch[i] = 16'($urandom);
            drive(1'($urandom_range(0, 3) != 0), SEL_W'($urandom), 1'($urandom_range(0, 4) != 0),
                  1'($urandom_range(0, 19) == 0));
            step();
        end

        // Async reset pulse mid-stream
        arst_n = 1'b0;
        #2;
        check_all_zero("arst");
        model_reset();
        #3;
        arst_n = 1'b1;
        drive(1'b1, 2'd2, 1'b1, 1'b0);
        step();
        drive(1'b0, 2'd0, 1'b1, 1'b0);
        step();
        chk("arst_first_early", {31'd0, o3_valid}, 32'd0);
        step();
        chk("arst_first", {16'd0, o3_data}, {16'd0, ch[2]});

        for (int n = 0; n < 200; n++) begin
            for (int i = 0; i < NUM_IN; i++) ch[i] = 16'($urandom);
            drive(1'($urandom_range(0, 3) != 0), SEL_W'($urandom), 1'($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 15) == 0));
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mux_n_pipe.md
# mux_n_pipe

Parametrised N-input datapath multiplexer with a configurable-depth output pipeline, stall (enable) and flush control, and valid tracking. It is the general-purpose successor to the fixed 3-input forwarding/operand muxes in the pipelined core. It is used wherever a selected operand must be registered across one or more stage boundaries, for example the forwarding unit feeding the ALU and the writeback-select path. Channel count, data width and latency are compile-time parameters.

## Interface

- NUM_IN, 3, number of input channels (2..16)
- DATA_W, 16, width of each channel in bits
- LATENCY, 1, number of register stages between input and output (1..4)
- SEL_W, $clog2(NUM_IN), select width (derived; do not override)

- clk  input  1  rising-edge clock; the block's only clock
- arst_n  input  1  asynchronous, active-low reset
- en  input  1  pipeline advance; 0 = all stages hold
- flush  input  1  synchronous kill of every in-flight item
- in_valid  input  1  qualifies in_data/sel this cycle
- in_data  input  NUM_IN*DATA_W  packed channels; channel k = bits [k*DATA_W +: DATA_W]
- sel  input  SEL_W  binary channel index
- out_data  output  DATA_W  selected data after LATENCY advancing cycles
- out_valid  output  1  out_data carries a live item
- sel_err  output  1  item at output was selected with an out-of-range sel (MUX_N_PIPE_SELERR_EN only)
- err_cnt  output  8  saturating count of accepted out-of-range selects (MUX_N_PIPE_SELERR_EN only)

## Operation

- Selection is combinational at the input: sel = k with k < NUM_IN picks channel k. sel ≥ NUM_IN picks channel 0 and is flagged as out-of-range.
- The selected word and in_valid enter stage 1. Stages 2..LATENCY shift on each cycle with en = 1.
- en = 0: every stage (data, valid, error tag) holds. Inputs that cycle are dropped, not queued.
- flush = 1: every stage valid and error tag clear to 0 and data clears to 0 at the next edge, regardless of en. Inputs presented that cycle are dropped.
- in_valid = 0 with en = 1 inserts a bubble: valid 0 and data 0 enter stage 1.
- No internal state machine beyond the shift pipeline; control priority is arst_n > flush > en.

## Timing

- Reset (arst_n = 0, asynchronous): out_data = 0, out_valid = 0, sel_err = 0, err_cnt = 0, all internal stages 0. Release is synchronous to the next clk edge.
- Latency: an item accepted at edge t appears on the outputs after edge t+LATENCY−1, provided en = 1 at every intermediate edge. Each en = 0 cycle adds one cycle.
- Throughput: one item per cycle while en = 1.
- flush and en both high on the same edge: flush wins; the pipeline empties.
- Reset asserted mid-stream: all items are lost immediately; no partial output.
- Outputs are driven directly from the last stage register, with no combinational path from any input to any output.

## Configuration

- MUX_N_PIPE_SELERR_EN defined: an error tag travels with each item through the pipeline, and sel_err mirrors the tag of the output stage.
  - err_cnt increments by 1 at each edge where in_valid = 1, en = 1, flush = 0 and sel ≥ NUM_IN.
  - err_cnt saturates at 255 and is cleared only by reset, not by flush.
- Not defined: no tag or counter logic is synthesised, and sel_err and err_cnt are tied to 0. The port list is identical in both builds.

## Test plan

- NUM_IN=3, DATA_W=16, LATENCY=1: channels = 0x1111/0x2222/0x3333, sel=2, in_valid=1, en=1 -> out_data=0x3333, out_valid=1 one edge later. sel=0 -> 0x1111.
- LATENCY=3, sel stepping 0,1,2 on consecutive cycles -> outputs 0x1111, 0x2222, 0x3333 on edges 3, 4, 5; out_valid high for exactly those three cycles.
- LATENCY=3, en held 0 for 2 cycles with one item in flight -> item emerges 2 cycles later, with the value unchanged.
- Flush asserted while 3 items are in flight, together with en=1 -> out_valid=0 and out_data=0 the next cycle; later items resume normally.
- With MUX_N_PIPE_SELERR_EN, NUM_IN=3, sel=3 -> out_data=0x1111, sel_err=1 aligned with that item, err_cnt=1. After 300 such selects, err_cnt=255. Without the macro, both sel_err and err_cnt stay 0.
- arst_n pulsed low for half a cycle mid-stream -> all outputs 0 immediately; the first new item appears after LATENCY edges.
